// File: rtl/code_class_counter.sv
// code_class_counter: classifies accepted 3-bit codes into three bins,
// presents each code with its class on a one-deep valid/ready output
// register, and keeps saturating per-bin and illegal-code counters.
// Codes outside {0,1,2,4} are flagged and can optionally halt intake
// until clr is pulsed.
module code_class_counter #(
  parameter int CNT_W       = 8,
  parameter bit HALT_ON_ERR = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_code,
  input  logic             clr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [2:0]       out_code,
  output logic [1:0]       out_class,
  output logic [CNT_W-1:0] cnt_lo,
  output logic [CNT_W-1:0] cnt_mid,
  output logic [CNT_W-1:0] cnt_hi,
  output logic [CNT_W-1:0] err_cnt,
  output logic             unique_err,
  output logic             halted
);

  typedef enum logic {RUN = 1'b0, HALT = 1'b1} state_t;

  state_t     state, state_nx;
  logic       accept;
  logic [1:0] cls_p0;
  logic       ill_p0;

  // Priority decode; first match wins, so every code gets a class.
  function automatic logic [1:0] classify(input logic [2:0] c);
    if (c[2:1] == 2'b00)
      return 2'd0;
    else if (c[2] == 1'b0)
      return 2'd1;
    else
      return 2'd2;
  endfunction

  // Legal codes form the one-hot-or-zero set {0,1,2,4}.
  function automatic logic is_illegal(input logic [2:0] c);
    return !((c == 3'd0) || (c == 3'd1) || (c == 3'd2) || (c == 3'd4));
  endfunction

  // Increment that sticks at the all-ones value instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (v == {CNT_W{1'b1}})
      return v;
    else
      return v + CNT_W'(1);
  endfunction

  // ---- stage 0: handshake and decode of the incoming code ----
  assign accept = in_valid && in_ready;
  assign cls_p0 = classify(in_code);
  assign ill_p0 = is_illegal(in_code);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state <= RUN;
    else
      state <= state_nx;
  end

  // Next state: clr forces RUN, but an illegal code accepted in the same
  // cycle still wins and halts (clear applies first, then the accept).
  always_comb begin
    state_nx = state;
    if (clr)
      state_nx = RUN;
    if (HALT_ON_ERR && accept && ill_p0)
      state_nx = HALT;
  end

  // FSM outputs; in_ready depends combinationally on out_ready.
  always_comb begin
    in_ready = (state == RUN) && (!out_valid || out_ready);
    halted   = (state == HALT);
  end

  // ---- stage 1: registered result, held until downstream takes it ----
  // Output register: load on accept, otherwise drain when consumed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_code  <= 3'd0;
      out_class <= 2'd0;
    end else if (accept) begin
      out_valid <= 1'b1;
      out_code  <= in_code;
      out_class <= cls_p0;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  // Bin and error counters plus the sticky flag; clr zeroes, then counts.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_lo     <= '0;
      cnt_mid    <= '0;
      cnt_hi     <= '0;
      err_cnt    <= '0;
      unique_err <= 1'b0;
    end else if (clr) begin
      cnt_lo     <= CNT_W'(accept && (cls_p0 == 2'd0));
      cnt_mid    <= CNT_W'(accept && (cls_p0 == 2'd1));
      cnt_hi     <= CNT_W'(accept && (cls_p0 == 2'd2));
      err_cnt    <= CNT_W'(accept && ill_p0);
      unique_err <= accept && ill_p0;
    end else if (accept) begin
      if (cls_p0 == 2'd0) cnt_lo  <= sat_inc(cnt_lo);
      if (cls_p0 == 2'd1) cnt_mid <= sat_inc(cnt_mid);
      if (cls_p0 == 2'd2) cnt_hi  <= sat_inc(cnt_hi);
      if (ill_p0) begin
        err_cnt    <= sat_inc(err_cnt);
        unique_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_code_class_counter.sv
// Directed bench for code_class_counter. Three instances share one set of
// inputs: a (CNT_W=8, no halt), b (CNT_W=8, halt on error) and
// c (CNT_W=2, no halt); each scenario checks the instance it targets.
module tb_code_class_counter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic [2:0] in_code;
  logic       clr;
  logic       out_ready;

  logic       a_in_ready, a_out_valid, a_unique_err, a_halted;
  logic [2:0] a_out_code;
  logic [1:0] a_out_class;
  logic [7:0] a_cnt_lo, a_cnt_mid, a_cnt_hi, a_err_cnt;

  logic       b_in_ready, b_out_valid, b_unique_err, b_halted;
  logic [2:0] b_out_code;
  logic [1:0] b_out_class;
  logic [7:0] b_cnt_lo, b_cnt_mid, b_cnt_hi, b_err_cnt;

  logic       c_in_ready, c_out_valid, c_unique_err, c_halted;
  logic [2:0] c_out_code;
  logic [1:0] c_out_class;
  logic [1:0] c_cnt_lo, c_cnt_mid, c_cnt_hi, c_err_cnt;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  code_class_counter #(.CNT_W(8), .HALT_ON_ERR(1'b0)) dut_a (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(a_in_ready),
    .in_code(in_code), .clr(clr), .out_valid(a_out_valid), .out_ready(out_ready),
    .out_code(a_out_code), .out_class(a_out_class), .cnt_lo(a_cnt_lo),
    .cnt_mid(a_cnt_mid), .cnt_hi(a_cnt_hi), .err_cnt(a_err_cnt),
    .unique_err(a_unique_err), .halted(a_halted));

  code_class_counter #(.CNT_W(8), .HALT_ON_ERR(1'b1)) dut_b (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(b_in_ready),
    .in_code(in_code), .clr(clr), .out_valid(b_out_valid), .out_ready(out_ready),
    .out_code(b_out_code), .out_class(b_out_class), .cnt_lo(b_cnt_lo),
    .cnt_mid(b_cnt_mid), .cnt_hi(b_cnt_hi), .err_cnt(b_err_cnt),
    .unique_err(b_unique_err), .halted(b_halted));

  code_class_counter #(.CNT_W(2), .HALT_ON_ERR(1'b0)) dut_c (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(c_in_ready),
    .in_code(in_code), .clr(clr), .out_valid(c_out_valid), .out_ready(out_ready),
    .out_code(c_out_code), .out_class(c_out_class), .cnt_lo(c_cnt_lo),
    .cnt_mid(c_cnt_mid), .cnt_hi(c_cnt_hi), .err_cnt(c_err_cnt),
    .unique_err(c_unique_err), .halted(c_halted));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Advance one clock edge and settle just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_code   = 3'd0;
    clr       = 1'b0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    int cls_exp[8];
    cls_exp = '{0, 0, 1, 1, 2, 2, 2, 2};

    // Reset state
    do_reset();
    chk("rst_out_valid", a_out_valid, 0);
    chk("rst_out_code", a_out_code, 0);
    chk("rst_cnt_lo", a_cnt_lo, 0);
    chk("rst_err_cnt", a_err_cnt, 0);
    chk("rst_unique_err", a_unique_err, 0);
    chk("rst_halted", b_halted, 0);
    chk("rst_in_ready", a_in_ready, 1);

    // 1: codes 0..7 at full throughput, no halting
    in_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      in_code = 3'(i);
      step();
      chk("t1_out_valid", a_out_valid, 1);
      chk("t1_out_code", a_out_code, i);
      chk("t1_out_class", a_out_class, cls_exp[i]);
      chk("t1_halted", a_halted, 0);
    end
    in_valid = 1'b0;
    chk("t1_cnt_lo", a_cnt_lo, 2);
    chk("t1_cnt_mid", a_cnt_mid, 2);
    chk("t1_cnt_hi", a_cnt_hi, 4);
    chk("t1_err_cnt", a_err_cnt, 4);
    chk("t1_unique_err", a_unique_err, 1);

    // 2: halt on illegal code 3, then clr releases and 4 is accepted
    do_reset();
    in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_code = 3'(i);
      step();
    end
    chk("t2_out_code3", b_out_code, 3);
    chk("t2_cnt_mid", b_cnt_mid, 2);
    chk("t2_err_cnt", b_err_cnt, 1);
    chk("t2_halted", b_halted, 1);
    chk("t2_in_ready", b_in_ready, 0);
    in_code = 3'd4;
    step();
    step();
    chk("t2_hi_blocked", b_cnt_hi, 0);
    chk("t2_drained", b_out_valid, 0);
    clr = 1'b1;
    step();
    clr = 1'b0;
    chk("t2_clr_halted", b_halted, 0);
    chk("t2_clr_mid", b_cnt_mid, 0);
    chk("t2_clr_err", b_err_cnt, 0);
    chk("t2_clr_uerr", b_unique_err, 0);
    chk("t2_clr_hi", b_cnt_hi, 0);
    step();
    in_valid = 1'b0;
    chk("t2_cnt_hi", b_cnt_hi, 1);
    chk("t2_out_code4", b_out_code, 4);

    // 3: backpressure holds code 2 while code 4 waits
    do_reset();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_code   = 3'd2;
    step();
    in_code = 3'd4;
    for (int i = 0; i < 5; i++) begin
      chk("t3_hold_valid", a_out_valid, 1);
      chk("t3_hold_code", a_out_code, 2);
      chk("t3_in_ready", a_in_ready, 0);
      step();
    end
    out_ready = 1'b1;
    #1;
    chk("t3_ready_comb", a_in_ready, 1);
    step();
    in_valid = 1'b0;
    chk("t3_next_code", a_out_code, 4);
    chk("t3_next_valid", a_out_valid, 1);
    chk("t3_cnt_mid", a_cnt_mid, 1);
    chk("t3_cnt_hi", a_cnt_hi, 1);
    step();
    chk("t3_empty", a_out_valid, 0);
    chk("t3_cnt_hi_once", a_cnt_hi, 1);

    // 4: saturation on the 2-bit instance
    do_reset();
    in_valid = 1'b1;
    in_code  = 3'd0;
    repeat (6) step();
    in_valid = 1'b0;
    chk("t4_cnt_lo", c_cnt_lo, 3);
    chk("t4_cnt_mid", c_cnt_mid, 0);
    chk("t4_cnt_hi", c_cnt_hi, 0);
    chk("t4_err_cnt", c_err_cnt, 0);

    // 5: clr coincident with accept of illegal code 5
    do_reset();
    in_valid = 1'b1;
    in_code  = 3'd0;
    repeat (7) step();
    chk("t5_pre_lo", a_cnt_lo, 7);
    in_code = 3'd5;
    clr     = 1'b1;
    step();
    clr       = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    chk("t5_cnt_lo", a_cnt_lo, 0);
    chk("t5_cnt_hi", a_cnt_hi, 1);
    chk("t5_err_cnt", a_err_cnt, 1);
    chk("t5_unique_err", a_unique_err, 1);
    chk("t5_halted_a", a_halted, 0);
    chk("t5_halted_b", b_halted, 1);
    chk("t5_b_err_cnt", b_err_cnt, 1);

    // 6: asynchronous reset mid-cycle with a pending output
    step();
    chk("t6_pending", a_out_valid, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_async_valid", a_out_valid, 0);
    chk("t6_async_code", a_out_code, 0);
    chk("t6_async_hi", a_cnt_hi, 0);
    chk("t6_async_err", a_err_cnt, 0);
    chk("t6_async_uerr", a_unique_err, 0);
    chk("t6_async_halt", b_halted, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    out_ready = 1'b1;
    in_code   = 3'bxxx;
    step();
    chk("t6_x_code", a_out_code, 0);
    chk("t6_x_lo", a_cnt_lo, 0);
    chk("t6_x_err", a_err_cnt, 0);
    in_valid = 1'b1;
    in_code  = 3'd2;
    step();
    in_valid = 1'b0;
    chk("t6_post_valid", a_out_valid, 1);
    chk("t6_post_class", a_out_class, 1);
    chk("t6_post_mid", a_cnt_mid, 1);
    chk("t6_post_lo", a_cnt_lo, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/code_class_counter.md
Name: code_class_counter

Overview:
- Downstream consumer of the 3-bit code stream (values 0..7) driven by the stimulus sequencer.
- Classifies each accepted code with a priority decode into one of three bins, registers the result on a valid/ready output, and keeps per-bin saturating counters.
- Flags codes outside the legal unique set {0,1,2,4}. It can optionally halt intake on such a code until software clears it.

Parameters:
- CNT_W, 8: width of each bin counter and of the error counter.
- HALT_ON_ERR, 1: 1 = enter HALT on an illegal code; 0 = flag and count only, never halt.

Ports:
- clk  in  1  single clock; all state updates on posedge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  upstream code valid.
- in_ready  out  1  block can accept a code this cycle.
- in_code  in  3  code value 0..7.
- clr  in  1  synchronous clear of counters, sticky flag and HALT.
- out_valid  out  1  registered result valid.
- out_ready  in  1  downstream accepts result.
- out_code  out  3  accepted code, registered.
- out_class  out  2  0 = codes 0/1, 1 = codes 2/3, 2 = codes 4..7; 3 never produced.
- cnt_lo / cnt_mid / cnt_hi  out  CNT_W each  accepted codes per class 0/1/2.
- err_cnt  out  CNT_W  accepted illegal codes (3, 5, 6, 7).
- unique_err  out  1  sticky: at least one illegal code accepted since reset/clr.
- halted  out  1  FSM is in HALT.

Behaviour:
- Reset (rst_n low, async): out_valid=0, out_code=0, out_class=0, all counters=0, unique_err=0, halted=0, FSM=RUN. Release is synchronous to clk.
- Accept: accept = in_valid && in_ready.
  - in_ready = (state==RUN) && (!out_valid || out_ready). This is a combinational path from out_ready.
- Classification uses priority order, first match wins:
  - in_code[2:1]==00 -> class 0;
  - else in_code[2]==0 -> class 1;
  - else class 2.
  - The decode is total, so every code gets a class.
- Latency: 1 cycle. On accept at edge N, out_code/out_class are loaded and out_valid=1 from edge N onward.
- Output hold: out_valid stays 1 and the data stays stable until out_ready is high at an edge. If that edge has no accept, out_valid goes to 0.
- Back-to-back: accept and out_ready in the same cycle replace the output register. There are no bubbles at full throughput.
- Counters: on accept, increment the counter of the classified bin by 1.
  - Saturate at 2^CNT_W-1; no wrap.
  - err_cnt increments (saturating) when the accepted code is in {3,5,6,7}.
- unique_err: set on accept of an illegal code; stays set until clr or reset.
- FSM states: RUN, HALT.
  - RUN -> HALT: accept of an illegal code with HALT_ON_ERR=1. The transition takes effect at the same edge, so the illegal code itself is accepted, classified and counted.
  - HALT -> RUN: clr=1.
  - In HALT, in_ready=0. A pending output still drains normally through out_ready.
  - halted = (state==HALT).
- clr (synchronous, 1 cycle):
  - Zeroes all four counters, clears unique_err, forces RUN.
  - Does not touch out_valid/out_code/out_class.
  - clr and accept in the same cycle: clear is applied first, then the count. Result: the hit bin = 1, others = 0.
  - If that accepted code is illegal: err_cnt=1 and unique_err=1; with HALT_ON_ERR=1 the state is HALT.
- Reset mid-transfer: the in-flight output is dropped (out_valid=0 immediately); counters are lost.
- in_code is ignored when not accepted.
- X on in_code while in_valid=0 must not propagate to any state.

Test Plan:
1. Sequence 0..7, one per cycle, out_ready=1, HALT_ON_ERR=0.
   - out_class sequence is 0,0,1,1,2,2,2,2, each 1 cycle after accept.
   - Final counters: cnt_lo=2, cnt_mid=2, cnt_hi=4, err_cnt=4; unique_err=1; halted=0 throughout.
2. HALT_ON_ERR=1, send 0,1,2,3,4.
   - Code 3 is accepted (cnt_mid=2, err_cnt=1) and halted=1 from the next cycle.
   - in_ready=0, so 4 is not accepted.
   - Pulse clr: counters become 0, halted=0, then 4 is accepted and cnt_hi=1.
3. Backpressure: out_ready=0 with code 2 sent.
   - out_valid=1, out_code=2 held for 5 cycles; in_ready=0; a second code 4 waits.
   - Raise out_ready: 4 appears the next cycle with no lost or duplicated codes.
4. Saturation with CNT_W=2: send 6 zeros.
   - cnt_lo sticks at 3; the other counters stay 0.
5. clr coincident with accept of code 5 (HALT_ON_ERR=0) while cnt_lo=7.
   - Next cycle: cnt_lo=0, cnt_hi=1, err_cnt=1, unique_err=1.
6. Assert rst_n low asynchronously mid-cycle with out_valid=1 and counters nonzero.
   - All outputs go to reset values before the next clk edge; after release, the first accept behaves as after power-up.
